// File: rtl/rob_pkg.sv
// Shared types and constants for the out-of-order read responder.
// Provides the delay-mode enum, LFSR taps/step function and the per-slot
// record used to track one outstanding read request.
package rob_pkg;

  typedef enum logic {
    DELAY_BY_ID = 1'b0,
    DELAY_LFSR  = 1'b1
  } delay_mode_e;

  localparam int unsigned LFSR_W   = 8;
  localparam int unsigned SEQ_W    = 4;
  localparam int unsigned TIMER_W  = 4;
  // Widest ID a slot can hold; ID_WIDTH of the responder must not exceed it.
  localparam int unsigned MAX_ID_W = 16;

  // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b1011_1000;

  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
    logic [SEQ_W-1:0]    seq;
    logic [TIMER_W-1:0]  timer;
  } slot_t;

  // One LFSR step: shift left, feedback is XOR of tapped bits.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/prio_pick.sv
// Lowest-index priority picker.
// Ports:
//   req_i - request vector, one bit per slot
//   gnt_o - one-hot grant of the lowest set request bit (zero if none)
//   any_o - high when any request bit is set
module prio_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o,
  output logic         any_o
);

  // x & -x isolates the lowest set bit.
  assign gnt_o = req_i & (~req_i + N'(1));
  assign any_o = |req_i;

endmodule

// File: rtl/ooo_read_responder.sv
// Out-of-order AXI-style read responder.
// Accepts AR requests into a small slot pool, gives each a per-slot delay
// (from the ID or an LFSR), and returns R beats from the lowest-index slot
// whose delay has expired, through a single registered output stage.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   s_arid_i          - read address ID
//   s_arvalid_i/_o    - AR handshake (s_arready_o high while a slot is free)
//   s_rdata_o         - {stored ID, accept sequence number}, zero-extended
//   s_rid_o           - response ID
//   s_rvalid_o/_i     - R handshake (s_rready_i from the master)
module ooo_read_responder
  import rob_pkg::*;
#(
  parameter int unsigned       DATA_WIDTH = 8,
  parameter int unsigned       ID_WIDTH   = 4,
  parameter int unsigned       SLOTS      = 4,
  parameter int unsigned       DELAY_MODE = 0,
  parameter logic [LFSR_W-1:0] LFSR_SEED  = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   s_arid_i,
  input  logic                  s_arvalid_i,
  output logic                  s_arready_o,
  output logic [DATA_WIDTH-1:0] s_rdata_o,
  output logic [ID_WIDTH-1:0]   s_rid_o,
  output logic                  s_rvalid_o,
  input  logic                  s_rready_i
);

  localparam bit USE_LFSR = (DELAY_MODE == 32'(DELAY_LFSR));

  slot_t                 slot_q [SLOTS];
  slot_t                 slot_d [SLOTS];
  logic [SEQ_W-1:0]      seq_q,    seq_d;
  logic [LFSR_W-1:0]     lfsr_q,   lfsr_d;
  logic                  rvalid_q, rvalid_d;
  logic [ID_WIDTH-1:0]   rid_q,    rid_d;
  logic [DATA_WIDTH-1:0] rdata_q,  rdata_d;

  logic [SLOTS-1:0]      free_req,  free_gnt;
  logic [SLOTS-1:0]      elig_req,  elig_gnt;
  logic                  free_any,  elig_any;

  logic                  ar_fire;
  logic                  out_load;
  logic [TIMER_W-1:0]    new_delay;
  logic [MAX_ID_W-1:0]   sel_id;
  logic [SEQ_W-1:0]      sel_seq;

  // Slot status vectors feeding the two pickers.
  always_comb begin
    free_req = '0;
    elig_req = '0;
    for (int i = 0; i < SLOTS; i++) begin
      free_req[i] = ~slot_q[i].valid;
      elig_req[i] = slot_q[i].valid && (slot_q[i].timer == '0);
    end
  end

  prio_pick #(.N(SLOTS)) u_free_pick (
    .req_i (free_req),
    .gnt_o (free_gnt),
    .any_o (free_any)
  );

  prio_pick #(.N(SLOTS)) u_elig_pick (
    .req_i (elig_req),
    .gnt_o (elig_gnt),
    .any_o (elig_any)
  );

  // Next-state logic for slots, counters and the R output stage.
  always_comb begin
    slot_d    = slot_q;
    seq_d     = seq_q;
    lfsr_d    = lfsr_q;
    rvalid_d  = rvalid_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    sel_id    = '0;
    sel_seq   = '0;

    ar_fire   = s_arvalid_i && free_any;
    out_load  = elig_any && (!rvalid_q || s_rready_i);
    new_delay = USE_LFSR ? (TIMER_W'(lfsr_q[2:0]) + TIMER_W'(1))
                         : (TIMER_W'(s_arid_i[2:0]) + TIMER_W'(1));

    // Grant is one-hot, so OR-reduction acts as the mux.
    for (int i = 0; i < SLOTS; i++) begin
      if (elig_gnt[i]) begin
        sel_id  = sel_id  | slot_q[i].id;
        sel_seq = sel_seq | slot_q[i].seq;
      end
    end

    // Freeing and filling never target the same slot: one picks valid,
    // the other picks invalid entries.
    for (int i = 0; i < SLOTS; i++) begin
      if (slot_q[i].timer != '0) begin
        slot_d[i].timer = slot_q[i].timer - TIMER_W'(1);
      end
      if (out_load && elig_gnt[i]) begin
        slot_d[i].valid = 1'b0;
      end
      if (ar_fire && free_gnt[i]) begin
        slot_d[i].valid = 1'b1;
        slot_d[i].id    = MAX_ID_W'(s_arid_i);
        slot_d[i].seq   = seq_q;
        slot_d[i].timer = new_delay;
      end
    end

    if (ar_fire) begin
      seq_d  = seq_q + SEQ_W'(1);
      lfsr_d = lfsr_next(lfsr_q);
    end

    if (out_load) begin
      rvalid_d = 1'b1;
      rid_d    = ID_WIDTH'(sel_id);
      rdata_d  = DATA_WIDTH'({ID_WIDTH'(sel_id), sel_seq});
    end else if (s_rready_i) begin
      rvalid_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SLOTS; i++) begin
        slot_q[i] <= '0;
      end
      seq_q    <= '0;
      lfsr_q   <= LFSR_SEED;
      rvalid_q <= 1'b0;
      rid_q    <= '0;
      rdata_q  <= '0;
    end else begin
      for (int i = 0; i < SLOTS; i++) begin
        slot_q[i] <= slot_d[i];
      end
      seq_q    <= seq_d;
      lfsr_q   <= lfsr_d;
      rvalid_q <= rvalid_d;
      rid_q    <= rid_d;
      rdata_q  <= rdata_d;
    end
  end

  // Ready depends only on slot valid flops, so it never combinationally
  // follows s_arvalid_i.
  assign s_arready_o = free_any;
  assign s_rvalid_o  = rvalid_q;
  assign s_rid_o     = rid_q;
  assign s_rdata_o   = rdata_q;

endmodule

// File: doc/ooo_read_responder.md
OOO_READ_RESPONDER -- requirements
Module: ooo_read_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: R data width; SHALL be >= ID_WIDTH+4.
REQ-002 SHALL have parameter ID_WIDTH, default 4: AR/R ID width.
REQ-003 SHALL have parameter SLOTS, default 4: outstanding-request capacity, power of two.
REQ-004 SHALL have parameter DELAY_MODE, default 0: 0 = delay set by ID, 1 = LFSR delay.
REQ-005 SHALL have parameter LFSR_SEED, default 8'hA5: LFSR reset value, nonzero.
REQ-006 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-007 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-008 SHALL have port s_arid_i, input, ID_WIDTH: read address ID.
REQ-009 SHALL have port s_arvalid_i, input, 1: AR valid.
REQ-010 SHALL have port s_arready_o, output, 1: AR ready.
REQ-011 SHALL have port s_rdata_o, output, DATA_WIDTH: read data.
REQ-012 SHALL have port s_rid_o, output, ID_WIDTH: response ID.
REQ-013 SHALL have port s_rvalid_o, output, 1: R valid.
REQ-014 SHALL have port s_rready_i, input, 1: R ready.

Function
REQ-015 SHALL accept an AR on an edge where s_arvalid_i and s_arready_o are both high; it SHALL store the ID, the delay and the 4-bit accept sequence number in the lowest-index free slot, then increment the sequence number modulo 16.
REQ-016 SHALL drive s_arready_o high when at least one slot is free, from registered state only; a slot freed on an edge SHALL be reusable from the next cycle.
REQ-017 SHALL load delay d = s_arid_i[2:0]+1 (range 1..8) when DELAY_MODE=0.
REQ-018 SHALL load delay d = lfsr[2:0]+1 when DELAY_MODE=1; the 8-bit Fibonacci LFSR (taps 8,6,5,4) SHALL advance only on AR acceptance.
REQ-019 SHALL hold a per-slot timer that loads d on acceptance and decrements by 1 each later edge while nonzero; a slot SHALL be eligible when it is valid and its timer is 0.
REQ-020 SHALL hold the R output as a register stage; it SHALL load when an eligible slot exists and (s_rvalid_o low or s_rready_i high); on load it SHALL free the slot.
REQ-021 SHALL choose the lowest-index eligible slot when several are eligible, so responses MAY be out of order versus ID order.
REQ-022 SHALL set s_rdata_o = {stored ID, stored sequence number}, zero-extended to DATA_WIDTH.
REQ-023 SHALL assert s_rvalid_o no earlier than edge N+d+1 for an AR accepted on edge N; if the output is blocked, it SHALL be asserted later.
REQ-024 SHALL keep s_rvalid_o, s_rid_o and s_rdata_o stable while s_rvalid_o is high and s_rready_i is low.
REQ-025 SHALL drop s_rvalid_o on the next edge after a handshake unless another slot is eligible; a back-to-back response with no bubble is allowed.
REQ-026 SHALL handle AR accept and R output load on the same edge independently.
REQ-027 SHALL hold at most SLOTS requests in slots plus 1 in the output register.

Reset
REQ-028 SHALL, while rst is high at an edge, clear all slot valid bits and timers, set the sequence number to 0, set the LFSR to LFSR_SEED, and clear s_rvalid_o, s_rid_o and s_rdata_o to 0.
REQ-029 SHALL discard outstanding requests when rst is asserted mid-operation and SHALL issue no responses for them; s_arready_o SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-030 SHALL take the delay-mode enum, LFSR taps and slot record typedef (valid, id, seq, timer) from a shared package, rob_pkg.
REQ-031 SHALL implement lowest-index selection in one sub-module, prio_pick (SLOTS-bit request vector in, one-hot grant plus any-valid out); this sub-module is used for both free-slot and eligible-slot search.

Verification (DELAY_MODE=0, DATA_WIDTH=8, ID_WIDTH=4, SLOTS=4)
REQ-032 SHALL cover reset: after rst high for 2 cycles -> s_rvalid_o=0, s_rid_o=0, s_rdata_o=0, s_arready_o=1.
REQ-033 SHALL cover a single AR: ID 4'h2 accepted on edge 0 with s_rready_i=1 -> s_rvalid_o high from edge 4, s_rid_o=4'h2, s_rdata_o=8'h20.
REQ-034 SHALL cover reordering: IDs 7, 1, 4 accepted on edges 0, 1, 2 -> R order 1, 4, 7 with data 8'h11, 8'h42, 8'h70, rvalid at edges 4, 8, 9.
REQ-035 SHALL cover full and backpressure: 4 ARs of ID 4'h7 with s_rready_i=0 -> s_arready_o=0 after the 4th accept and returns to 1 when the first slot moves to output; rvalid/rid/rdata stay stable until s_rready_i=1.
REQ-036 SHALL cover reset mid-flight: 3 requests outstanding, rst pulsed for 1 cycle -> no s_rvalid_o for 20 cycles, and a new AR gets sequence number 0.
REQ-037 SHALL cover a tie: IDs 4'h3 and 4'hb accepted on edges 0 and 1 (ready edges 4 and 5), rready=0 until edge 6 -> slot 0 (ID 3) returned first, ID b next, with no bubble.
